// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: PC sequencing, redirect/epoch handling and an
// in-order tracking FIFO of outstanding requests. Perf counters built only when FETCH_CTRL_PERF_EN is defined.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_redir_valid,
    input  logic [31:0] ex_redir_pc,
    input  logic        dc_redir_valid,
    input  logic [31:0] dc_redir_pc,
    input  logic [31:0] bp_next_pc,
    output logic        im_req_valid,
    input  logic        im_req_ready,
    output logic [31:0] im_addr,
    input  logic        im_resp_valid,
    output logic        fetch_valid,
    output logic [31:0] fetch_pc,
    output logic [1:0]  fetch_epoch,
    output logic        resp_err,
    output logic [15:0] perf_redir_cnt,
    output logic [15:0] perf_squash_cnt
);

    localparam int             PW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int             SLOTS   = 1 << PW;
    localparam logic [PW-1:0]  LAST    = PW'(DEPTH - 1);
    localparam logic [2:0]     DEPTH_C = 3'(DEPTH);

    typedef enum logic [1:0] {
        BOOT,
        RUN,
        PEND
    } state_t;

    state_t        state_reg, state_next;
    logic [31:0]   pc_reg, pc_next;
    logic [1:0]    epoch_reg, epoch_next;
    logic [31:0]   pend_pc_reg, pend_pc_next;
    logic          pend_src_reg, pend_src_next;
    logic          req_hold_reg, req_hold_next;
    logic [PW-1:0] rd_ptr_reg, wr_ptr_reg;
    logic [2:0]    count_reg;
    logic          resp_err_reg;

    logic [31:0]   ent_pc_reg    [SLOTS];
    logic [1:0]    ent_epoch_reg [SLOTS];
    logic          ent_live_reg  [SLOTS];

    logic          redir_any;
    logic [31:0]   redir_tgt;
    logic          fifo_full;
    logic          fifo_empty;
    logic          req_valid;
    logic          redir_apply;
    logic          push;
    logic          pop;
    logic          head_live;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + 1'b1;
    endfunction

    assign redir_any  = ex_redir_valid | dc_redir_valid;
    assign redir_tgt  = ex_redir_valid ? ex_redir_pc : dc_redir_pc;
    assign fifo_full  = (count_reg == DEPTH_C);
    assign fifo_empty = (count_reg == 3'd0);
    assign head_live  = ent_live_reg[rd_ptr_reg];

    assign im_req_valid = req_valid & ~rst;
    assign im_addr      = pc_reg;
    assign push         = im_req_valid & im_req_ready;
    assign pop          = im_resp_valid & ~fifo_empty;

    assign fetch_valid  = pop & head_live & ~rst;
    assign fetch_pc     = ent_pc_reg[rd_ptr_reg];
    assign fetch_epoch  = ent_epoch_reg[rd_ptr_reg];
    assign resp_err     = resp_err_reg;

    // A request that has been offered but not yet accepted must be held, so a
    // redirect arriving meanwhile either rides on the handshake or is parked.
    always_comb begin
        state_next    = state_reg;
        pc_next       = pc_reg;
        pend_pc_next  = pend_pc_reg;
        pend_src_next = pend_src_reg;
        req_valid     = 1'b0;
        redir_apply   = 1'b0;
        case (state_reg)
            BOOT: begin
                state_next = RUN;
            end
            RUN: begin
                req_valid = req_hold_reg | (~fifo_full & ~redir_any);
                if (redir_any) begin
                    if (!req_valid || im_req_ready) begin
                        redir_apply = 1'b1;
                        pc_next     = redir_tgt;
                    end else begin
                        pend_pc_next  = redir_tgt;
                        pend_src_next = ex_redir_valid;
                        state_next    = PEND;
                    end
                end else if (req_valid && im_req_ready) begin
                    pc_next = bp_next_pc;
                end
            end
            PEND: begin
                req_valid = 1'b1;
                if (ex_redir_valid) begin
                    pend_pc_next  = ex_redir_pc;
                    pend_src_next = 1'b1;
                end
                if (im_req_ready) begin
                    redir_apply   = 1'b1;
                    pc_next       = ex_redir_valid ? ex_redir_pc : pend_pc_reg;
                    pend_pc_next  = '0;
                    pend_src_next = 1'b0;
                    state_next    = RUN;
                end
            end
            default: begin
                state_next = BOOT;
            end
        endcase
    end

    assign epoch_next    = redir_apply ? epoch_reg + 2'd1 : epoch_reg;
    assign req_hold_next = (state_next == RUN) & req_valid & ~im_req_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= BOOT;
            pc_reg       <= RESET_PC;
            epoch_reg    <= 2'd0;
            pend_pc_reg  <= '0;
            pend_src_reg <= 1'b0;
            req_hold_reg <= 1'b0;
            rd_ptr_reg   <= '0;
            wr_ptr_reg   <= '0;
            count_reg    <= 3'd0;
            resp_err_reg <= 1'b0;
        end else begin
            state_reg    <= state_next;
            pc_reg       <= pc_next;
            epoch_reg    <= epoch_next;
            pend_pc_reg  <= pend_pc_next;
            pend_src_reg <= pend_src_next;
            req_hold_reg <= req_hold_next;
            if (push) begin
                wr_ptr_reg <= ptr_inc(wr_ptr_reg);
            end
            if (pop) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case ({push, pop})
                2'b10:   count_reg <= count_reg + 3'd1;
                2'b01:   count_reg <= count_reg - 3'd1;
                default: count_reg <= count_reg;
            endcase
            if (im_resp_valid && fifo_empty) begin
                resp_err_reg <= 1'b1;
            end
        end
    end

    // A request accepted in the same cycle as a redirect is already stale.
    generate
        for (genvar gi = 0; gi < SLOTS; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (rst) begin
                    ent_live_reg[gi] <= 1'b0;
                end else if (push && (wr_ptr_reg == PW'(gi))) begin
                    ent_live_reg[gi] <= ~redir_apply;
                end else if (redir_apply) begin
                    ent_live_reg[gi] <= 1'b0;
                end
            end

            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == PW'(gi))) begin
                    ent_pc_reg[gi]    <= pc_reg;
                    ent_epoch_reg[gi] <= epoch_reg;
                end
            end
        end
    endgenerate

`ifdef FETCH_CTRL_PERF_EN
    logic [15:0] redir_cnt_reg;
    logic [15:0] squash_cnt_reg;
    logic        squash_evt;

    assign squash_evt = pop & ~head_live;

    always_ff @(posedge clk) begin
        if (rst) begin
            redir_cnt_reg  <= 16'd0;
            squash_cnt_reg <= 16'd0;
        end else begin
            if (redir_apply && (redir_cnt_reg != 16'hFFFF)) begin
                redir_cnt_reg <= redir_cnt_reg + 16'd1;
            end
            if (squash_evt && (squash_cnt_reg != 16'hFFFF)) begin
                squash_cnt_reg <= squash_cnt_reg + 16'd1;
            end
        end
    end

    assign perf_redir_cnt  = redir_cnt_reg;
    assign perf_squash_cnt = squash_cnt_reg;
`else
    assign perf_redir_cnt  = 16'd0;
    assign perf_squash_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Self-checking bench for fetch_ctrl: directed scenarios then randomized traffic,
// all checked against a queue-based reference model of the fetch rules.
module tb_fetch_ctrl;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_redir_valid;
    logic [31:0] ex_redir_pc;
    logic        dc_redir_valid;
    logic [31:0] dc_redir_pc;
    logic [31:0] bp_next_pc;
    logic        im_req_valid;
    logic        im_req_ready;
    logic [31:0] im_addr;
    logic        im_resp_valid;
    logic        fetch_valid;
    logic [31:0] fetch_pc;
    logic [1:0]  fetch_epoch;
    logic        resp_err;
    logic [15:0] perf_redir_cnt;
    logic [15:0] perf_squash_cnt;

    always #5 clk = ~clk;

    fetch_ctrl #(.RESET_PC(32'h0000_0000), .DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_redir_valid (ex_redir_valid),
        .ex_redir_pc    (ex_redir_pc),
        .dc_redir_valid (dc_redir_valid),
        .dc_redir_pc    (dc_redir_pc),
        .bp_next_pc     (bp_next_pc),
        .im_req_valid   (im_req_valid),
        .im_req_ready   (im_req_ready),
        .im_addr        (im_addr),
        .im_resp_valid  (im_resp_valid),
        .fetch_valid    (fetch_valid),
        .fetch_pc       (fetch_pc),
        .fetch_epoch    (fetch_epoch),
        .resp_err       (resp_err),
        .perf_redir_cnt (perf_redir_cnt),
        .perf_squash_cnt(perf_squash_cnt)
    );

    typedef struct {
        logic [31:0] pc;
        logic [1:0]  ep;
        bit          live;
    } ent_t;

    // Reference model: outstanding requests as a queue, plus architectural PC/epoch.
    ent_t        m_q[$];
    logic [31:0] m_pc;
    logic [31:0] m_pend_pc;
    logic [1:0]  m_ep;
    bit          m_boot, m_pend, m_hold, m_err;
    int unsigned m_redir, m_squash;

    int vectors     = 0;
    int miscompares = 0;

    logic        s_valid, s_fv, s_err;
    logic [31:0] s_addr, s_fpc;
    logic [1:0]  s_fep;
    logic [15:0] s_predir, s_psq;

    function automatic logic [15:0] perf_exp(input int unsigned n);
        logic [15:0] v;
        v = (n > 32'd65535) ? 16'hFFFF : 16'(n);
`ifndef FETCH_CTRL_PERF_EN
        v = 16'h0000;
`endif
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc      = 32'h0;
        m_pend_pc = 32'h0;
        m_ep      = 2'd0;
        m_boot    = 1'b1;
        m_pend    = 1'b0;
        m_hold    = 1'b0;
        m_err     = 1'b0;
        m_redir   = 0;
        m_squash  = 0;
    endtask

    task automatic push_entry();
        ent_t e;
        e.pc   = m_pc;
        e.ep   = m_ep;
        e.live = 1'b1;
        m_q.push_back(e);
    endtask

    task automatic kill_all();
        foreach (m_q[k]) m_q[k].live = 1'b0;
    endtask

    task automatic step(input bit r, input bit exv, input logic [31:0] expc,
                        input bit dcv, input logic [31:0] dcpc,
                        input bit rdy, input bit rsp, input bit rnd_bp);
        bit          v, fv;
        ent_t        e;
        logic [31:0] t;
        @(negedge clk);
        rst            = r;
        ex_redir_valid = exv;
        ex_redir_pc    = expc;
        dc_redir_valid = dcv;
        dc_redir_pc    = dcpc;
        im_req_ready   = rdy;
        im_resp_valid  = rsp;
        bp_next_pc     = rnd_bp ? ($urandom & 32'hFFFF_FFFC) : m_pc + 32'd4;
        v  = !r && !m_boot && (m_pend || m_hold || ((m_q.size() < DEPTH) && !exv && !dcv));
        fv = !r && rsp && (m_q.size() > 0) && m_q[0].live;
        #1;
        s_valid  = im_req_valid;
        s_addr   = im_addr;
        s_fv     = fetch_valid;
        s_fpc    = fetch_pc;
        s_fep    = fetch_epoch;
        s_err    = resp_err;
        s_predir = perf_redir_cnt;
        s_psq    = perf_squash_cnt;
        chk("im_req_valid", s_valid, v);
        if (v) chk("im_addr", s_addr, m_pc);
        chk("fetch_valid", s_fv, fv);
        if (rsp && (m_q.size() > 0)) begin
            chk("fetch_pc", s_fpc, m_q[0].pc);
            chk("fetch_epoch", s_fep, m_q[0].ep);
        end
        chk("resp_err", s_err, m_err);
        chk("perf_redir_cnt", s_predir, perf_exp(m_redir));
        chk("perf_squash_cnt", s_psq, perf_exp(m_squash));
        if (!r && v && rdy) $display("req  addr=%h epoch=%0d", m_pc, m_ep);
        if (!r && rsp) begin
            if (m_q.size() == 0) $display("resp with nothing outstanding");
            else $display("resp pc=%h epoch=%0d live=%0d", m_q[0].pc, m_q[0].ep, m_q[0].live);
        end
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            if (rsp) begin
                if (m_q.size() == 0) begin
                    m_err = 1'b1;
                end else begin
                    e = m_q.pop_front();
                    if (!e.live) m_squash++;
                end
            end
            if (m_boot) begin
                m_boot = 1'b0;
            end else if (m_pend) begin
                if (exv) m_pend_pc = expc;
                if (rdy) begin
                    push_entry();
                    kill_all();
                    m_pc   = m_pend_pc;
                    m_ep   = m_ep + 2'd1;
                    m_redir++;
                    m_pend = 1'b0;
                end
            end else if (exv || dcv) begin
                t = exv ? expc : dcpc;
                if (!v || rdy) begin
                    if (v) push_entry();
                    kill_all();
                    m_pc = t;
                    m_ep = m_ep + 2'd1;
                    m_redir++;
                end else begin
                    m_pend    = 1'b1;
                    m_pend_pc = t;
                end
            end else if (v && rdy) begin
                push_entry();
                m_pc = bp_next_pc;
            end
            m_hold = !m_pend && v && !rdy;
        end
    endtask

    task automatic idle(input bit rdy, input bit rsp);
        step(1'b0, 1'b0, 32'h0, 1'b0, 32'h0, rdy, rsp, 1'b0);
    endtask

    task automatic do_reset();
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst            = 1'b1;
        ex_redir_valid = 1'b0;
        ex_redir_pc    = 32'h0;
        dc_redir_valid = 1'b0;
        dc_redir_pc    = 32'h0;
        bp_next_pc     = 32'h4;
        im_req_ready   = 1'b0;
        im_resp_valid  = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();

        // Sequential fetch, BOOT bubble, outstanding cap
        idle(1, 0);  chk("boot_no_req", s_valid, 0);
        idle(1, 0);  chk("seq_addr0", s_addr, 32'h0);
        idle(1, 0);  chk("seq_addr4", s_addr, 32'h4);
        idle(1, 0);  chk("depth_cap", s_valid, 0);
        idle(1, 1);  chk("resp0_pc", s_fpc, 32'h0);
        idle(1, 1);  chk("seq_addr8", s_addr, 32'h8);
        idle(1, 1);  chk("resp8_valid", s_fv, 1);
        idle(0, 1);

        // Mispredict with two outstanding
        do_reset();
        idle(1, 0);
        idle(1, 0);
        idle(1, 0);
        step(0, 1, 32'h100, 0, 32'h0, 1, 0, 0);
        idle(1, 1);  chk("squash_a", s_fv, 0);
        idle(1, 1);  chk("squash_b", s_fv, 0);  chk("redir_addr", s_addr, 32'h100);
        idle(0, 1);  chk("new_epoch", s_fep, 2'd1);  chk("squash_cnt2", s_psq, perf_exp(2));

        // Redirect while request is stalled
        do_reset();
        idle(1, 0);
        idle(1, 0);
        idle(1, 0);
        idle(0, 1);
        idle(0, 1);  chk("stall_addr8", s_addr, 32'h8);
        step(0, 0, 32'h0, 1, 32'h40, 0, 0, 0);  chk("pend_hold_a", s_addr, 32'h8);
        step(0, 1, 32'h80, 0, 32'h0, 0, 0, 0);  chk("pend_hold_b", s_addr, 32'h8);
        step(0, 0, 32'h0, 1, 32'h44, 0, 0, 0);  chk("pend_dc_ign", s_addr, 32'h8);
        idle(1, 0);  chk("pend_accept", s_addr, 32'h8);
        idle(0, 1);  chk("pend_squash", s_fv, 0);  chk("pend_target", s_addr, 32'h80);

        // Simultaneous ex and dc redirect
        do_reset();
        idle(1, 0);
        step(0, 1, 32'h200, 1, 32'h300, 1, 0, 0);
        idle(1, 0);  chk("ex_wins", s_addr, 32'h200);  chk("redir_cnt1", s_predir, perf_exp(1));
        idle(0, 1);  chk("ex_epoch", s_fep, 2'd1);

        // Stray response, sticky error
        do_reset();
        idle(0, 0);
        idle(0, 1);  chk("stray_no_fetch", s_fv, 0);
        idle(0, 0);  chk("err_set", s_err, 1);
        idle(1, 1);
        idle(0, 0);  chk("err_sticky", s_err, 1);
        do_reset();
        idle(0, 0);  chk("err_cleared", s_err, 0);

        // Reset drops outstanding entries
        idle(1, 0);
        idle(1, 0);
        do_reset();
        idle(0, 1);
        idle(0, 0);  chk("reset_drop_err", s_err, 1);

        // Randomized traffic
        do_reset();
        for (int i = 0; i < 800; i++) begin
            bit r, exv, dcv, rdy, rsp, rb;
            r   = ($urandom_range(0, 199) == 0);
            exv = ($urandom_range(0, 99) < 5);
            dcv = ($urandom_range(0, 99) < 8);
            rdy = ($urandom_range(0, 99) < 70);
            rsp = (m_q.size() > 0) ? ($urandom_range(0, 99) < 50) : ($urandom_range(0, 99) < 2);
            rb  = ($urandom_range(0, 99) < 10);
            step(r, exv, $urandom & 32'hFFFF_FFFC, dcv, $urandom & 32'hFFFF_FFFC, rdy, rsp, rb);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fetch_ctrl.md
FETCH_CTRL -- requirements
Module: fetch_ctrl

Interface
REQ-001 Parameters SHALL be: RESET_PC, 32'h0000_0000, first fetch address after reset; DEPTH, 2, maximum outstanding instruction-memory requests (legal 1..4).
REQ-002 Ports SHALL be (clock and reset first):
  clk  in  1  single clock, all state on rising edge
  rst  in  1  synchronous, active-high reset
  ex_redir_valid  in  1  execute-stage mispredict redirect
  ex_redir_pc  in  32  execute redirect target
  dc_redir_valid  in  1  decode-stage early redirect
  dc_redir_pc  in  32  decode redirect target
  bp_next_pc  in  32  predicted next PC for current im_addr (combinational from the predictor)
  im_req_valid  out  1  fetch request valid
  im_req_ready  in  1  memory accepts request
  im_addr  out  32  fetch address
  im_resp_valid  in  1  in-order response for oldest outstanding request
  fetch_valid  out  1  live instruction delivered to decode
  fetch_pc  out  32  PC of delivered instruction
  fetch_epoch  out  2  redirect epoch of delivered instruction
  resp_err  out  1  sticky: response received with nothing outstanding
  perf_redir_cnt  out  16  accepted redirects
  perf_squash_cnt  out  16  squashed responses

Function
REQ-003 States SHALL be BOOT, RUN, PEND; BOOT lasts exactly one cycle after reset deassertion (no request), then RUN.
REQ-004 Tracking FIFO of DEPTH entries SHALL hold {pc, epoch, live} per accepted request, in order.
REQ-005 im_req_valid SHALL be high in RUN when FIFO count < DEPTH and no redirect is being applied that cycle, and in PEND unconditionally; im_addr = pc register.
REQ-006 Once asserted, im_req_valid and im_addr SHALL remain stable until im_req_ready is sampled high.
REQ-007 Handshake (valid & ready) SHALL push {pc, epoch, live=1}; in RUN with no redirect, pc <= bp_next_pc.
REQ-008 Redirect priority SHALL be ex over dc; simultaneous ex and dc selects ex_redir_pc.
REQ-009 Redirect in RUN with im_req_valid low SHALL apply immediately: pc <= target, epoch <= epoch+1 (mod 4), all FIFO live bits cleared; request resumes next cycle.
REQ-010 Redirect in RUN with im_req_valid high and im_req_ready high SHALL push the accepted request then clear all live bits including the new entry, pc <= target, epoch+1.
REQ-011 Redirect in RUN with im_req_valid high and im_req_ready low SHALL latch target and source into pending registers and enter PEND.
REQ-012 In PEND, ex redirect SHALL overwrite the pending target; dc redirect SHALL be ignored.
REQ-013 On handshake in PEND: push stalled request, then apply pending redirect per REQ-010; return to RUN.
REQ-014 im_resp_valid SHALL pop the FIFO head same cycle; fetch_valid = im_resp_valid & head.live; fetch_pc/fetch_epoch = head fields (combinational).
REQ-015 A squashed response (live=0) SHALL produce fetch_valid=0 and increment perf_squash_cnt.
REQ-016 im_resp_valid with empty FIFO SHALL set resp_err and be otherwise ignored.
REQ-017 Push and pop in the same cycle SHALL be legal; count unchanged.
REQ-018 Perf counters SHALL saturate at 16'hFFFF.

Reset
REQ-019 On rst: state BOOT, pc = RESET_PC, epoch = 0, FIFO empty, pending cleared, resp_err = 0, counters = 0; im_req_valid = 0, fetch_valid = 0.
REQ-020 Reset asserted mid-operation SHALL drop all outstanding entries; later responses set resp_err.

Configuration
REQ-021 Macro FETCH_CTRL_PERF_EN: defined -> perf_redir_cnt/perf_squash_cnt count per REQ-015/REQ-018; undefined -> counters not built, both ports tied to 0, all other behaviour identical.

Verification
REQ-022 Reset, ready always high, bp_next_pc = im_addr+4 -> no request in BOOT cycle; im_addr 0x0, 0x4, 0x8 on consecutive cycles; DEPTH=2 caps outstanding at 2 until responses.
REQ-023 Two requests (0x0, 0x4) outstanding, ex redirect to 0x100 -> both responses fetch_valid=0, perf_squash_cnt=2, next request im_addr=0x100, fetch_epoch=1.
REQ-024 im_req_ready low holding 0x8, dc redirect to 0x40, then ex redirect to 0x80 -> im_addr stays 0x8 until accepted, 0x8 response squashed, next request 0x80.
REQ-025 Same-cycle ex (0x200) and dc (0x300) redirect -> im_addr 0x200, epoch +1, perf_redir_cnt +1.
REQ-026 im_resp_valid with FIFO empty -> resp_err=1 and stays 1 until rst; fetch_valid=0.
REQ-027 Build without FETCH_CTRL_PERF_EN, rerun REQ-023 -> identical fetch behaviour, perf outputs 0.
